// File: rtl/fetch_unit.sv
// Instruction fetch stage: tags 1-cycle memory responses with their address, delivers them
// in order to the decoder and steers the PC stage for branch redirects and replays.
module fetch_unit #(
  parameter int IW      = 16,
  parameter int AW      = 8,
  parameter int TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_addr,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] instr_addr,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          br_valid,
  input  logic [AW-1:0] br_target,
  output logic          pc_load,
  output logic [AW-1:0] pc_load_addr
);

  localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  logic [AW-1:0] rsp_tag;
  logic          rsp_v;
  logic [AW-1:0] exp_addr;
  logic [CW-1:0] to_cnt;

  logic          match;
  logic          space;
  logic          accept;
  logic          replay;
  logic          to_fire;
  logic          reload;
  logic [AW-1:0] reload_addr;

  assign imem_addr = pc_addr;

  // NOTE: every signal gets a value on every path through always_comb, so no latches are inferred.
  always_comb begin
    match       = rsp_v && (rsp_tag == exp_addr);
    space       = !instr_valid || instr_ready;
    accept      = match && space && !br_valid;
    replay      = match && !space && !br_valid;
    to_fire     = (to_cnt == TO_LAST) && !br_valid && !replay && !accept;
    reload      = br_valid || replay || to_fire;
    reload_addr = br_valid ? br_target : exp_addr;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_tag <= '0;
      rsp_v   <= 1'b0;
    end else begin
      rsp_tag <= pc_addr;
      rsp_v   <= 1'b1;
    end
  end

  // Output register and owed-address tracking; a branch overrides everything else.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr       <= '0;
      instr_addr  <= '0;
      instr_valid <= 1'b0;
      exp_addr    <= '0;
    end else if (br_valid) begin
      instr_valid <= 1'b0;
      exp_addr    <= br_target;
    end else if (accept) begin
      instr       <= imem_rdata;
      instr_addr  <= rsp_tag;
      instr_valid <= 1'b1;
      exp_addr    <= exp_addr + AW'(1);
    end else if (instr_valid && instr_ready) begin
      instr_valid <= 1'b0;
    end
  end

  // Cleared whenever progress is made or a reload is issued, so timeout reloads repeat every TIMEOUT cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (accept || reload) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_LAST) begin
      to_cnt <= to_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_load      <= 1'b0;
      pc_load_addr <= '0;
    end else begin
      pc_load <= reload;
      if (reload) begin
        pc_load_addr <= reload_addr;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: PC-stage and memory models around the DUT, and an
// in-order delivery model (next owed address, redirected by branches) checking every handshake.
module tb_fetch_unit;

  localparam int IW      = 16;
  localparam int AW      = 8;
  localparam int TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] pc_addr;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_addr;
  logic          instr_valid;
  logic          instr_ready = 1'b1;
  logic          br_valid = 1'b0;
  logic [AW-1:0] br_target = '0;
  logic          pc_load;
  logic [AW-1:0] pc_load_addr;
  logic          pc_stuck = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.IW(IW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_addr      (pc_addr),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_addr   (instr_addr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr)
  );

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return 16'hA000 + IW'(a);
  endfunction

  // Free-running PC stage: a load of X shows X-1 next cycle, then X, X+1, ...
  always @(posedge clk or negedge reset) begin
    if (!reset)        pc_addr <= '0;
    else if (pc_stuck) pc_addr <= 8'h20;
    else if (pc_load)  pc_addr <= pc_load_addr - 8'd1;
    else               pc_addr <= pc_addr + 8'd1;
  end

  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  int            n_checks = 0;
  int            n_pass = 0;
  int            n_fail = 0;
  int            n_deliv = 0;
  logic [AW-1:0] m_exp = '0;
  logic          have_last = 1'b0;
  logic [AW-1:0] last_deliv = '0;
  logic          saw_wrap = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score any handshake against the model, advance to the next falling edge, check follow-ups.
  task automatic tick();
    logic          hs;
    logic          stall;
    logic          br;
    logic [AW-1:0] tgt;
    hs    = instr_valid && instr_ready;
    stall = instr_valid && !instr_ready && !br_valid;
    br    = br_valid;
    tgt   = br_target;
    if (hs) begin
      check("deliver_addr", 32'(instr_addr), 32'(m_exp));
      check("deliver_data", 32'(instr), 32'(mem_word(m_exp)));
      if (have_last && last_deliv == 8'hFF && instr_addr == 8'h00) saw_wrap = 1'b1;
      last_deliv = instr_addr;
      have_last  = 1'b1;
      n_deliv++;
      m_exp = m_exp + 8'd1;
    end
    if (br) m_exp = tgt;
    @(negedge clk);
    if (stall) begin
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_addr", 32'(instr_addr), 32'(m_exp));
      check("hold_data", 32'(instr), 32'(mem_word(m_exp)));
    end
    if (br) begin
      check("br_drop_valid", 32'(instr_valid), 32'd0);
      check("br_load", 32'(pc_load), 32'd1);
      check("br_load_addr", 32'(pc_load_addr), 32'(tgt));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int prev_k;
    int n_pulse;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_instr_addr", 32'(instr_addr), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_pc_load", 32'(pc_load), 32'd0);
    check("rst_pc_load_addr", 32'(pc_load_addr), 32'd0);

    // Release and first-delivery latency
    reset = 1'b1;
    m_exp = '0;
    tick();
    check("first_valid_early", 32'(instr_valid), 32'd0);
    tick();
    check("first_valid", 32'(instr_valid), 32'd1);
    check("first_addr", 32'(instr_addr), 32'd0);
    check("first_data", 32'(instr), 32'hA000);

    // Decoder stall on address 5 forces a replay of 6
    for (int i = 0; i < 20 && !(instr_valid && instr_addr == 8'd5); i++) tick();
    check("reach_5", 32'(instr_valid && instr_addr == 8'd5), 32'd1);
    instr_ready = 1'b0;
    tick();
    check("stall_instr", 32'(instr), 32'hA005);
    check("replay_load", 32'(pc_load), 32'd1);
    check("replay_addr", 32'(pc_load_addr), 32'd6);
    tick();
    tick();
    check("stall_instr_late", 32'(instr), 32'hA005);
    instr_ready = 1'b1;

    // Branch to 0x40 while 0x12 is presented
    for (int i = 0; i < 60 && !(instr_valid && instr_addr == 8'h12); i++) tick();
    check("reach_12", 32'(instr_valid && instr_addr == 8'h12), 32'd1);
    br_valid  = 1'b1;
    br_target = 8'h40;
    tick();
    br_valid = 1'b0;
    d0 = n_deliv;
    for (int i = 0; i < 20 && n_deliv == d0; i++) tick();
    check("br_next_addr", 32'(last_deliv), 32'h40);

    // Address wrap 0xFF -> 0x00 without any reload
    br_valid  = 1'b1;
    br_target = 8'hFC;
    tick();
    br_valid = 1'b0;
    saw_wrap = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("wrap_no_reload", 32'(pc_load), 32'd0);
    end
    check("wrap_seen", 32'(saw_wrap), 32'd1);

    // PC stuck at 0x20 while 0x30 is owed: timeout reloads every TIMEOUT cycles
    pc_stuck  = 1'b1;
    br_valid  = 1'b1;
    br_target = 8'h30;
    tick();
    br_valid = 1'b0;
    prev_k   = 0;
    n_pulse  = 0;
    for (int k = 1; k <= 26; k++) begin
      tick();
      check("to_no_deliver", 32'(instr_valid), 32'd0);
      if (pc_load) begin
        n_pulse++;
        check("to_addr", 32'(pc_load_addr), 32'h30);
        check("to_period", 32'(k - prev_k), 32'(TIMEOUT));
        prev_k = k;
      end
    end
    check("to_pulses", 32'(n_pulse), 32'd3);
    pc_stuck = 1'b0;
    d0 = n_deliv;
    for (int i = 0; i < 30; i++) tick();
    check("to_recover", 32'(n_deliv > d0), 32'd1);

    // Randomized decoder back-pressure and branches
    d0 = n_deliv;
    for (int i = 0; i < 400; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      br_valid    = ($urandom_range(0, 19) == 0);
      br_target   = AW'($urandom);
      tick();
    end
    instr_ready = 1'b1;
    br_valid    = 1'b0;
    check("rand_progress", 32'(n_deliv - d0 >= 40), 32'd1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 30 && !instr_valid; i++) tick();
    check("pre_reset_valid", 32'(instr_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_instr", 32'(instr), 32'd0);
    check("arst_instr_addr", 32'(instr_addr), 32'd0);
    check("arst_instr_valid", 32'(instr_valid), 32'd0);
    check("arst_pc_load", 32'(pc_load), 32'd0);
    check("arst_pc_load_addr", 32'(pc_load_addr), 32'd0);
    @(negedge clk);
    reset     = 1'b1;
    m_exp     = '0;
    have_last = 1'b0;
    tick();
    check("restart_valid_early", 32'(instr_valid), 32'd0);
    tick();
    check("restart_valid", 32'(instr_valid), 32'd1);
    check("restart_addr", 32'(instr_addr), 32'd0);
    for (int i = 0; i < 4; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
